// File: rtl/mem_bank.sv
// Single-port word memory with a power-on zeroing sweep, one-cycle registered
// reads and an error pulse for addresses beyond DEPTH-1.
module mem_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             ready,
    output logic             err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             inrange;
    logic             acc;

    // Addresses are AW bits wide, so DEPTH..2**AW-1 exist when DEPTH is not a power of two.
    assign inrange = ({1'b0, addr} < DEPTH_W);
    assign acc     = ready & sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && cnt == LAST) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        ready = (state == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_INIT) begin
            cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
        end
    end

    // The array itself has no reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[cnt] <= '0;
        end else if (acc && wr && inrange) begin
            mem[addr] <= wdata;
        end
    end

    // Read stage: request at edge N, data and rvalid visible after edge N
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= acc & ~wr;
            err    <= acc & ~inrange;
            if (acc && !wr) begin
                rdata <= inrange ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank.sv
// Bench for mem_bank: a DEPTH=16 and a DEPTH=12 instance share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_mem_bank;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;

    logic [15:0] rdata16, rdata12;
    logic        rvalid16, rvalid12, ready16, ready12, err16, err12;

    int total;
    int bad;

    // Reference model: index 0 is the DEPTH=16 instance, index 1 the DEPTH=12 instance.
    int          dep [2] = '{16, 12};
    logic [15:0] mm [2][16];
    logic [15:0] e_rd [2];
    logic        e_rv [2];
    logic        e_er [2];
    int          since;

    wire [37:0] got = {rdata16, rvalid16, err16, ready16, rdata12, rvalid12, err12, ready12};

    mem_bank #(.WIDTH(16), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata16), .rvalid(rvalid16), .ready(ready16), .err(err16)
    );

    mem_bank #(.WIDTH(16), .DEPTH(12)) u12 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata12), .rvalid(rvalid12), .ready(ready12), .err(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] model_out();
        logic r0, r1;
        r0 = (since >= dep[0]);
        r1 = (since >= dep[1]);
        return {e_rd[0], e_rv[0], e_er[0], r0, e_rd[1], e_rv[1], e_er[1], r1};
    endfunction

    // One accepted-or-ignored request per clock, applied to both models.
    task automatic model_edge(input logic s, input logic w, input logic [3:0] a, input logic [15:0] d);
        for (int k = 0; k < 2; k++) begin
            if (since >= dep[k] && s) begin
                e_er[k] = (int'(a) >= dep[k]);
                if (w) begin
                    e_rv[k] = 1'b0;
                    if (int'(a) < dep[k]) mm[k][a] = d;
                end else begin
                    e_rv[k] = 1'b1;
                    e_rd[k] = (int'(a) < dep[k]) ? mm[k][a] : 16'h0000;
                end
            end else begin
                e_rv[k] = 1'b0;
                e_er[k] = 1'b0;
            end
        end
        since++;
    endtask

    task automatic cycle(input logic s, input logic w, input logic [3:0] a, input logic [15:0] d);
        sel   = s;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(s, w, a, d);
        #1;
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear before any edge, then releases.
    task automatic do_reset(input string tag);
        sel = 1'b0;
        rst = 1'b1;
        since = 0;
        for (int k = 0; k < 2; k++) begin
            e_rd[k] = '0;
            e_rv[k] = 1'b0;
            e_er[k] = 1'b0;
        end
        #2;
        total++;
        if (got !== model_out()) begin
            bad++;
            $display("FAIL %s async_clear got=%h want=%h", tag, got, model_out());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        since = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 16; j++) mm[k][j] = 16'h0000;
    endtask

    task automatic test_reset();
        do_reset("reset");
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 16'h0);
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL sweep_cycle%0d got=%h want=%h", i, got, model_out());
            end
            total++;
            if (ready16 !== (i >= 16)) begin
                bad++;
                $display("FAIL ready16_cycle%0d got=%b want=%b", i, ready16, (i >= 16));
            end
        end
        for (int a = 0; a < 16; a++) begin
            cycle(1'b1, 1'b0, 4'(a), 16'h0);
            total++;
            if (got !== model_out() || rdata16 !== 16'h0000 || rvalid16 !== 1'b1) begin
                bad++;
                $display("FAIL zero_read addr=%0d got=%h want=%h", a, got, model_out());
            end
        end
    endtask

    task automatic test_write_read();
        cycle(1'b1, 1'b1, 4'd3, 16'h0056);
        total++;
        if (got !== model_out() || rvalid16 !== 1'b0) begin
            bad++;
            $display("FAIL write3 got=%h want=%h", got, model_out());
        end
        cycle(1'b1, 1'b0, 4'd3, 16'h0);
        total++;
        if (rdata16 !== 16'h0056 || rvalid16 !== 1'b1 || got !== model_out()) begin
            bad++;
            $display("FAIL read3 rdata=%h rvalid=%b want rdata=0056 rvalid=1", rdata16, rvalid16);
        end
        cycle(1'b0, 1'b0, 4'd0, 16'h0);
        total++;
        if (rvalid16 !== 1'b0 || rdata16 !== 16'h0056 || got !== model_out()) begin
            bad++;
            $display("FAIL rvalid_drop rdata=%h rvalid=%b want rdata=0056 rvalid=0", rdata16, rvalid16);
        end
    endtask

    task automatic test_sel_idle();
        cycle(1'b0, 1'b1, 4'd3, 16'h00AB);
        total++;
        if (rvalid16 !== 1'b0 || err16 !== 1'b0 || got !== model_out()) begin
            bad++;
            $display("FAIL idle_write got=%h want=%h", got, model_out());
        end
        cycle(1'b1, 1'b0, 4'd3, 16'h0);
        total++;
        if (rdata16 !== 16'h0056 || rvalid16 !== 1'b1 || got !== model_out()) begin
            bad++;
            $display("FAIL idle_readback rdata=%h want=0056", rdata16);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b1, 4'd5, 16'h1234);
        cycle(1'b1, 1'b0, 4'd3, 16'h0);
        total++;
        if (rdata16 !== 16'h0056 || rvalid16 !== 1'b1 || got !== model_out()) begin
            bad++;
            $display("FAIL b2b_first rdata=%h rvalid=%b want rdata=0056 rvalid=1", rdata16, rvalid16);
        end
        cycle(1'b1, 1'b0, 4'd5, 16'h0);
        total++;
        if (rdata16 !== 16'h1234 || rvalid16 !== 1'b1 || got !== model_out()) begin
            bad++;
            $display("FAIL b2b_second rdata=%h rvalid=%b want rdata=1234 rvalid=1", rdata16, rvalid16);
        end
        cycle(1'b0, 1'b0, 4'd0, 16'h0);
        total++;
        if (rvalid16 !== 1'b0 || rdata16 !== 16'h1234) begin
            bad++;
            $display("FAIL b2b_end rdata=%h rvalid=%b want rdata=1234 rvalid=0", rdata16, rvalid16);
        end
    endtask

    task automatic test_out_of_range();
        cycle(1'b1, 1'b1, 4'd13, 16'h7777);
        total++;
        if (err12 !== 1'b1 || rvalid12 !== 1'b0 || got !== model_out()) begin
            bad++;
            $display("FAIL oor_write err=%b rvalid=%b want err=1 rvalid=0", err12, rvalid12);
        end
        cycle(1'b1, 1'b0, 4'd13, 16'h0);
        total++;
        if (err12 !== 1'b1 || rvalid12 !== 1'b1 || rdata12 !== 16'h0000 || got !== model_out()) begin
            bad++;
            $display("FAIL oor_read err=%b rvalid=%b rdata=%h want err=1 rvalid=1 rdata=0000",
                     err12, rvalid12, rdata12);
        end
        cycle(1'b0, 1'b0, 4'd0, 16'h0);
        total++;
        if (err12 !== 1'b0 || got !== model_out()) begin
            bad++;
            $display("FAIL oor_pulse err=%b want=0", err12);
        end
        for (int a = 0; a < 12; a++) begin
            cycle(1'b1, 1'b0, 4'(a), 16'h0);
            total++;
            if (got !== model_out() || err12 !== 1'b0) begin
                bad++;
                $display("FAIL oor_inrange addr=%0d got=%h want=%h", a, got, model_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 16'($urandom));
            total++;
            if (got !== model_out()) begin
                bad++;
                $display("FAIL random_%0d got=%h want=%h", i, got, model_out());
            end
        end
    endtask

    task automatic test_reset_midsweep();
        do_reset("run_reset");
        for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b0, 4'd0, 16'h0);
        total++;
        if (ready16 !== 1'b0 || got !== model_out()) begin
            bad++;
            $display("FAIL midsweep_pre got=%h want=%h", got, model_out());
        end
        do_reset("mid_reset");
        for (int i = 1; i <= 16; i++) begin
            if (i == 1) cycle(1'b1, 1'b1, 4'd2, 16'hBEEF);
            else        cycle(1'b0, 1'b0, 4'd0, 16'h0);
            total++;
            if (got !== model_out() || ready16 !== (i >= 16)) begin
                bad++;
                $display("FAIL midsweep_cycle%0d got=%h want=%h", i, got, model_out());
            end
        end
        for (int a = 0; a < 16; a++) begin
            cycle(1'b1, 1'b0, 4'(a), 16'h0);
            total++;
            if (got !== model_out() || rdata16 !== 16'h0000) begin
                bad++;
                $display("FAIL midsweep_read addr=%0d got=%h want=%h", a, got, model_out());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        since = 0;
        rst   = 1'b1;
        sel   = 1'b0;
        wr    = 1'b0;
        addr  = 4'd0;
        wdata = 16'h0;
        #1;
        test_reset();
        test_write_read();
        test_sel_idle();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_reset_midsweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
